mul_32_seq: RTL



---
 rtl/mul_32_seq.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mul_32_seq.sv
// Sequential 32x32 signed Booth multiplier with start/busy/done handshake.
// Define MUL_RADIX4_EN for radix-4 Booth (16 steps); default is radix-2 (32 steps).
module mul_32_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

`ifdef MUL_RADIX4_EN
  localparam int unsigned N  = 16;
  localparam int unsigned AW = 34;
`else
  localparam int unsigned N  = 32;
  localparam int unsigned AW = 33;
`endif
  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [31:0]     m_reg;
  logic [AW-1:0]   acc;
  logic [31:0]     q;
  logic            q_m1;
  logic [CW-1:0]   cnt;

  logic [AW-1:0]   m_ext;
  logic [AW-1:0]   addend;
  logic [AW-1:0]   sum;
  logic [AW-1:0]   acc_nxt;
  logic [31:0]     q_nxt;
  logic            q_m1_nxt;

  assign m_ext = {{(AW-32){m_reg[31]}}, m_reg};

  // One Booth step: select the partial product, add, then shift {acc,q,q_m1} right.
  always_comb begin
    addend   = '0;
    sum      = '0;
    acc_nxt  = acc;
    q_nxt    = q;
    q_m1_nxt = q_m1;
`ifdef MUL_RADIX4_EN
    case ({q[1:0], q_m1})
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = m_ext << 1;
      3'b100:         addend = -(m_ext << 1);
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
    sum      = acc + addend;
    acc_nxt  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    q_nxt    = {sum[1:0], q[31:2]};
    q_m1_nxt = q[1];
`else
    case ({q[0], q_m1})
      2'b01:   addend = m_ext;
      2'b10:   addend = -m_ext;
      default: addend = '0;
    endcase
    sum      = acc + addend;
    acc_nxt  = {sum[AW-1], sum[AW-1:1]};
    q_nxt    = {sum[0], q[31:1]};
    q_m1_nxt = q[0];
`endif
  end

  // Control FSM and datapath registers; hi/lo load only on the final step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      m_reg <= '0;
      acc   <= '0;
      q     <= '0;
      q_m1  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m_reg <= multiplicand;
            q     <= multiplier;
            acc   <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          q    <= q_nxt;
          q_m1 <= q_m1_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            hi    <= acc_nxt[31:0];
            lo    <= q_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
